// File: rtl/noc_tg_pkg.sv
// Shared types and field layout for the AXI-Stream traffic generator.
// Optional feature macro: AXIS_TG_RANDOM_DEST_EN (enables the random-destination LFSR).
package noc_tg_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RR     = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_RSVD   = 2'd3
    } tg_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tg_state_e;

    // tdata layout: source id in the top byte, sequence number below it,
    // beat index in the bottom byte, everything else zero.
    localparam int SRC_FIELD_W  = 8;
    localparam int SEQ_FIELD_W  = 16;
    localparam int BEAT_FIELD_W = 8;
    localparam int HDR_W        = SRC_FIELD_W + SEQ_FIELD_W;
    localparam int LFSR_W       = 16;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/axis_tg_lfsr.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left.
// next_o is the value the register takes on the next step.
module axis_tg_lfsr
    import noc_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_i,
    output logic [15:0] value_o,
    output logic [15:0] next_o
);

    logic [15:0] lfsr_q;

    assign next_o  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign value_o = lfsr_q;

    // Advance one position per requested step; reset loads the (fixed-up) seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= lfsr_seed_fix(SEED);
        end else if (step_i) begin
            lfsr_q <= next_o;
        end
    end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator for one mesh endpoint: multi-beat packets with
// self-describing tdata to a fixed, round-robin or random destination.
// Optional feature macro: AXIS_TG_RANDOM_DEST_EN (cfg_mode 2 = random via LFSR;
// without it cfg_mode 2 behaves as round-robin and no LFSR is built).
module axis_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int          TDATA_WIDTH      = 32,
    parameter int          TDEST_WIDTH      = 4,
    parameter int          NUM_DESTS        = 4,
    parameter int          SRC_ID           = 0,
    parameter int          LEN_WIDTH        = 8,
    parameter int          GAP_WIDTH        = 4,
    parameter int          DISABLE_SELFLOOP = 0,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic [TDEST_WIDTH-1:0] cfg_dest_i,
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_len_i,
    input  logic [15:0]            cfg_num_pkts_i,
    input  logic [GAP_WIDTH-1:0]   cfg_gap_i,
    output logic                   axis_out_tvalid_o,
    input  logic                   axis_out_tready_i,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata_o,
    output logic                   axis_out_tlast_o,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            pkt_count_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    tg_state_e              state_q;
    tg_mode_e               mode_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [15:0]            num_q;
    logic [GAP_WIDTH-1:0]   gap_q;
    logic [GAP_WIDTH-1:0]   gap_cnt_q;
    logic [LEN_WIDTH-1:0]   beat_q;
    logic [15:0]            seq_q;
    logic [15:0]            pkt_count_q;
    logic [TDEST_WIDTH-1:0] dest_q;
    logic                   abort_q;
    logic                   tvalid_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic                   tlast_q;
    logic [TDEST_WIDTH-1:0] tdest_q;
    logic                   busy_q;
    logic                   done_q;

    tg_mode_e               start_mode_d;
    logic [LEN_WIDTH-1:0]   start_len_d;
    logic [TDEST_WIDTH-1:0] start_dest_d;
    logic [TDEST_WIDTH-1:0] adv_dest_d;
    logic                   tx_accept;
    logic                   run_end_d;

    // Reduce a destination mod NUM_DESTS, then hop over our own id if self-loops are off.
    function automatic logic [TDEST_WIDTH-1:0] dest_wrap(input int d);
        int m;
        m = d % NUM_DESTS;
        if (DISABLE_SELFLOOP != 0 && m == SRC_ID) begin
            m = (m + 1) % NUM_DESTS;
        end
        return TDEST_WIDTH'(m);
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] make_tdata(input logic [15:0] seq,
                                                          input logic [LEN_WIDTH-1:0] beat);
        logic [TDATA_WIDTH-1:0] d;
        d = '0;
        d[TDATA_WIDTH-1 -: HDR_W] = {8'(SRC_ID), seq};
        d[BEAT_FIELD_W-1:0]       = 8'(beat);
        return d;
    endfunction

`ifdef AXIS_TG_RANDOM_DEST_EN
    logic        lfsr_step;
    logic [15:0] lfsr_value;
    logic [15:0] lfsr_next;

    // The LFSR moves once per finished packet, and only while generating random traffic.
    assign lfsr_step = (state_q == SEND) && tx_accept && tlast_q && (mode_q == MODE_RANDOM);

    axis_tg_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (lfsr_step),
        .value_o (lfsr_value),
        .next_o  (lfsr_next)
    );
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign tx_accept = tvalid_q && axis_out_tready_i;
    assign run_end_d = abort_q || abort_i || (num_q != 16'd0 && (pkt_count_q + 16'd1) == num_q);
    assign start_len_d = (cfg_pkt_len_i == '0) ? LEN_ONE : cfg_pkt_len_i;

    // Decode the requested mode; reserved behaves as fixed, random falls back to round-robin when not built.
    always_comb begin
        start_mode_d = MODE_FIXED;
        case (cfg_mode_i)
            2'd1:    start_mode_d = MODE_RR;
`ifdef AXIS_TG_RANDOM_DEST_EN
            2'd2:    start_mode_d = MODE_RANDOM;
`else
            2'd2:    start_mode_d = MODE_RR;
`endif
            default: start_mode_d = MODE_FIXED;
        endcase
    end

    // Destination of the first packet of a run, and of the packet following the current one.
    always_comb begin
        start_dest_d = cfg_dest_i;
        adv_dest_d   = dest_q;
        case (start_mode_d)
            MODE_RR:     start_dest_d = dest_wrap(int'(cfg_dest_i));
`ifdef AXIS_TG_RANDOM_DEST_EN
            MODE_RANDOM: start_dest_d = dest_wrap(int'(lfsr_value));
`endif
            default:     ;
        endcase
        case (mode_q)
            MODE_RR:     adv_dest_d = dest_wrap(int'(dest_q) + 1);
`ifdef AXIS_TG_RANDOM_DEST_EN
            MODE_RANDOM: adv_dest_d = dest_wrap(int'(lfsr_next));
`endif
            default:     ;
        endcase
    end

    // Main sequencer: IDLE -> SEND <-> GAP -> DONE -> IDLE, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FIXED;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            beat_q      <= '0;
            seq_q       <= '0;
            pkt_count_q <= '0;
            dest_q      <= '0;
            abort_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tdest_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q      <= start_mode_d;
                        len_q       <= start_len_d;
                        num_q       <= cfg_num_pkts_i;
                        gap_q       <= cfg_gap_i;
                        abort_q     <= abort_i;
                        pkt_count_q <= '0;
                        seq_q       <= '0;
                        beat_q      <= '0;
                        dest_q      <= start_dest_d;
                        tvalid_q    <= 1'b1;
                        tdata_q     <= make_tdata(16'd0, '0);
                        tlast_q     <= (start_len_d == LEN_ONE);
                        tdest_q     <= start_dest_d;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                    if (tx_accept) begin
                        if (!tlast_q) begin
                            beat_q  <= beat_q + LEN_ONE;
                            tdata_q <= make_tdata(seq_q, beat_q + LEN_ONE);
                            tlast_q <= ((beat_q + LEN_ONE) == (len_q - LEN_ONE));
                        end else begin
                            pkt_count_q <= pkt_count_q + 16'd1;
                            seq_q       <= seq_q + 16'd1;
                            dest_q      <= adv_dest_d;
                            beat_q      <= '0;
                            if (run_end_d) begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end else if (gap_q != '0) begin
                                tvalid_q  <= 1'b0;
                                tlast_q   <= 1'b0;
                                gap_cnt_q <= gap_q - GAP_ONE;
                                state_q   <= GAP;
                            end else begin
                                tdata_q <= make_tdata(seq_q + 16'd1, '0);
                                tlast_q <= (len_q == LEN_ONE);
                                tdest_q <= adv_dest_d;
                            end
                        end
                    end
                end
                GAP: begin
                    if (abort_q || abort_i) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (gap_cnt_q == '0) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= make_tdata(seq_q, '0);
                        tlast_q  <= (len_q == LEN_ONE);
                        tdest_q  <= dest_q;
                        state_q  <= SEND;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign axis_out_tvalid_o = tvalid_q;
    assign axis_out_tdata_o  = tdata_q;
    assign axis_out_tlast_o  = tlast_q;
    assign axis_out_tdest_o  = tdest_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pkt_count_o       = pkt_count_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: a table of run configurations plus
// randomized runs, each checked beat by beat against a packet-level model.
module tb_axis_traffic_gen;

    localparam int          TDW  = 32;
    localparam int          TSW  = 4;
    localparam int          ND   = 4;
    localparam int          SRC  = 1;
    localparam int          LW   = 8;
    localparam int          GW   = 4;
    localparam int          SELF = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic [1:0]     cfg_mode_i = '0;
    logic [TSW-1:0] cfg_dest_i = '0;
    logic [LW-1:0]  cfg_pkt_len_i = '0;
    logic [15:0]    cfg_num_pkts_i = '0;
    logic [GW-1:0]  cfg_gap_i = '0;
    logic           tready_i = 1'b0;
    logic           tvalid_o;
    logic [TDW-1:0] tdata_o;
    logic           tlast_o;
    logic [TSW-1:0] tdest_o;
    logic           busy_o;
    logic           done_o;
    logic [15:0]    pkt_count_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] lfsr_m;
    int          obs_q[$];

    always #5 clk = ~clk;

    axis_traffic_gen #(
        .TDATA_WIDTH      (TDW),
        .TDEST_WIDTH      (TSW),
        .NUM_DESTS        (ND),
        .SRC_ID           (SRC),
        .LEN_WIDTH        (LW),
        .GAP_WIDTH        (GW),
        .DISABLE_SELFLOOP (SELF),
        .LFSR_SEED        (SEED)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .cfg_mode_i        (cfg_mode_i),
        .cfg_dest_i        (cfg_dest_i),
        .cfg_pkt_len_i     (cfg_pkt_len_i),
        .cfg_num_pkts_i    (cfg_num_pkts_i),
        .cfg_gap_i         (cfg_gap_i),
        .axis_out_tvalid_o (tvalid_o),
        .axis_out_tready_i (tready_i),
        .axis_out_tdata_o  (tdata_o),
        .axis_out_tlast_o  (tlast_o),
        .axis_out_tdest_o  (tdest_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pkt_count_o       (pkt_count_o)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1: feedback is the XOR of the tapped stages.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        int  taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[k]) fb ^= s[taps[k]-1];
        return {s[14:0], fb};
    endfunction

    function automatic int skip_self(input int d);
        int m = d % ND;
        if (SELF != 0 && m == SRC) m = (m + 1) % ND;
        return m;
    endfunction

    // mode, dest, len, num, gap, ready pattern (0 always, 1 toggle, 2 random),
    // abort kind (0 none, 1 mid-packet, 2 with start, 3 in gap), abort packet, expected packets
    typedef struct {
        int mode; int dest; int len; int num; int gap;
        int rdy;  int amode; int apkt; int exp;
    } vec_t;

    vec_t tbl[11];

    task automatic run(input vec_t v, input int id);
        int L, eff_mode, cur_dest, pk, bt, idle, cyc;
        bit gap_mon, prev_v, prev_acc, done_due, fin, abort_gap_pending, first, acc;
        logic [TDW-1:0] pd, exp_d;
        logic           pl;
        logic [TSW-1:0] pdest;
        L = (v.len == 0) ? 1 : v.len;
`ifdef AXIS_TG_RANDOM_DEST_EN
        eff_mode = (v.mode == 1) ? 1 : (v.mode == 2) ? 2 : 0;
`else
        eff_mode = (v.mode == 1 || v.mode == 2) ? 1 : 0;
`endif
        pk = 0; bt = 0; idle = 0; cyc = 0;
        gap_mon = 0; prev_v = 0; prev_acc = 0; done_due = 0; fin = 0;
        abort_gap_pending = 0; first = 1;
        pd = '0; pl = 0; pdest = '0;
        obs_q.delete();

        // An abort while idle must have no lasting effect.
        @(negedge clk);
        abort_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("idle_tvalid", tvalid_o, 0);
        chk("idle_busy", busy_o, 0);
        abort_i        = 1'b0;
        cfg_mode_i     = 2'(v.mode);
        cfg_dest_i     = TSW'(v.dest);
        cfg_pkt_len_i  = LW'(v.len);
        cfg_num_pkts_i = 16'(v.num);
        cfg_gap_i      = GW'(v.gap);
        start_i        = 1'b1;
        abort_i        = (v.amode == 2);
        tready_i       = 1'b1;
        cur_dest = (eff_mode == 0) ? v.dest : (eff_mode == 1) ? skip_self(v.dest) : skip_self(int'(lfsr_m));

        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (v.amode == 2) abort_i = 1'b0;
            if (first) begin
                chk("first_beat_latency", tvalid_o, 1);
                first = 0;
            end
            if (done_due) begin
                chk("done_pulse", done_o, 1);
                chk("done_busy", busy_o, 0);
                chk("done_tvalid", tvalid_o, 0);
                chk("pkt_count", pkt_count_o, v.exp);
                abort_i = 1'b0;
                @(negedge clk);
                chk("done_one_cycle", done_o, 0);
                fin = 1;
                break;
            end
            chk("no_early_done", done_o, 0);
            if (prev_v && !prev_acc) begin
                chk("hold_stable", {tvalid_o, tdata_o, tlast_o, tdest_o}, {1'b1, pd, pl, pdest});
            end
            if (gap_mon) begin
                if (!tvalid_o) begin
                    idle++;
                    chk("gap_busy", busy_o, 1);
                    if (abort_gap_pending) begin
                        abort_i = 1'b1;
                        abort_gap_pending = 0;
                        done_due = 1;
                    end
                end else begin
                    chk("gap_len", idle, v.gap);
                    gap_mon = 0;
                end
            end
            if (tvalid_o) begin
                if (pk >= v.exp) begin
                    chk("extra_beat", 1, 0);
                    fin = 1;
                    break;
                end
                exp_d = {8'(SRC), 16'(pk), 8'(bt)};
                chk("tdata", tdata_o, exp_d);
                chk("tlast", tlast_o, (bt == L - 1));
                chk("tdest", tdest_o, cur_dest);
                chk("busy", busy_o, 1);
                if (eff_mode != 0) chk("no_selfloop", (tdest_o == TSW'(SRC)), 0);
                if (v.amode == 1 && pk == v.apkt && bt == ((L > 1) ? 1 : 0)) abort_i = 1'b1;
            end
            case (v.rdy)
                0:       tready_i = 1'b1;
                1:       tready_i = cyc[0];
                default: tready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (!done_due) begin
                cfg_mode_i     = 2'($urandom);
                cfg_dest_i     = TSW'($urandom);
                cfg_pkt_len_i  = LW'($urandom);
                cfg_num_pkts_i = 16'($urandom);
                cfg_gap_i      = GW'($urandom);
                start_i        = ($urandom_range(0, 7) == 0);
            end
            acc = tvalid_o && tready_i;
            if (acc) begin
                if (bt == L - 1) begin
                    obs_q.push_back(int'(tdest_o));
                    $display("run %0d pkt %0d dest %0d len %0d", id, pk, tdest_o, L);
                    pk++;
                    bt = 0;
                    if (eff_mode == 1) cur_dest = skip_self(cur_dest + 1);
                    else if (eff_mode == 2) begin
                        lfsr_m   = lfsr_adv(lfsr_m);
                        cur_dest = skip_self(int'(lfsr_m));
                    end
                    if (pk == v.exp && v.amode != 3) done_due = 1;
                    else begin
                        if (pk == v.exp) abort_gap_pending = 1;
                        gap_mon = 1;
                        idle = 0;
                    end
                end else begin
                    bt++;
                end
            end
            prev_v = tvalid_o; prev_acc = acc; pd = tdata_o; pl = tlast_o; pdest = tdest_o;
        end
        if (!fin) chk("timeout", 0, 1);
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic chk_dests(input string name, input int exp[]);
        chk({name, "_count"}, obs_q.size(), exp.size());
        foreach (exp[k]) begin
            if (k < obs_q.size()) chk(name, obs_q[k], exp[k]);
        end
    endtask

    initial begin
        int exp_rr0[] = '{0, 2, 3, 0, 2, 3};
        int exp_rr15[] = '{3, 0, 2, 3, 0};
        vec_t r;

        tbl[0]  = '{0, 1, 1, 1,  0, 0, 0, 0, 1};
        tbl[1]  = '{0, 2, 4, 3,  0, 0, 0, 0, 3};
        tbl[2]  = '{0, 3, 3, 2,  1, 1, 0, 0, 2};
        tbl[3]  = '{1, 0, 2, 6,  0, 0, 0, 0, 6};
        tbl[4]  = '{0, 0, 3, 0,  2, 0, 1, 5, 6};
        tbl[5]  = '{2, 0, 1, 64, 0, 2, 0, 0, 64};
        tbl[6]  = '{0, 2, 0, 2,  3, 2, 0, 0, 2};
        tbl[7]  = '{1, 15, 2, 5, 0, 2, 0, 0, 5};
        tbl[8]  = '{0, 1, 2, 0,  0, 0, 2, 0, 1};
        tbl[9]  = '{1, 1, 1, 0,  4, 0, 3, 2, 3};
        tbl[10] = '{3, 2, 2, 2,  0, 2, 0, 0, 2};

        // Reset state
        lfsr_m = SEED;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid_o, 0);
        chk("rst_tdata", tdata_o, 0);
        chk("rst_tlast", tlast_o, 0);
        chk("rst_tdest", tdest_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pkt_count", pkt_count_o, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i], i);
            if (i == 3) chk_dests("rr_dest_seq", exp_rr0);
            if (i == 7) chk_dests("rr_wrap_seq", exp_rr15);
        end

        for (int i = 0; i < 16; i++) begin
            r.mode  = $urandom_range(0, 3);
            r.dest  = (r.mode == 1) ? $urandom_range(0, 15) : $urandom_range(0, ND - 1);
            r.len   = $urandom_range(0, 6);
            r.gap   = $urandom_range(0, 3);
            r.rdy   = $urandom_range(0, 2);
            r.amode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r.apkt  = $urandom_range(0, 3);
            if (r.amode == 1) begin
                r.num = 0;
                r.exp = r.apkt + 1;
            end else begin
                r.num = $urandom_range(1, 5);
                r.exp = r.num;
            end
            run(r, 100 + i);
        end

        // Reset in the middle of a packet drops tvalid without waiting for a clock.
        @(negedge clk);
        cfg_mode_i = 2'd0; cfg_dest_i = 4'd2; cfg_pkt_len_i = 8'd8;
        cfg_num_pkts_i = 16'd0; cfg_gap_i = 4'd0; tready_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_tvalid", tvalid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_tvalid", tvalid_o, 0);
        chk("async_reset_busy", busy_o, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        lfsr_m = SEED;
        run(tbl[1], 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
